// File: rtl/countdown16_pkg.sv
// Shared definitions for the countdown16 timer: state encodings and default width.
package countdown16_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Encodings are fixed: IDLE=0, RUN=1.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/countdown16_dec16.sv
// Dec16: combinational minus-one (out = in - 1, modulo 2^WIDTH), ripple-borrow.
module Dec16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // Borrow ripples upward from the LSB until the first set bit absorbs it.
  always_comb begin
    logic v_borrow;
    v_borrow = 1'b1;
    out      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out[i]   = in[i] ^ v_borrow;
      v_borrow = v_borrow & ~in[i];
    end
  end

endmodule

// File: rtl/countdown16.sv
// countdown16: loadable down-counter with terminal-count pulse and optional auto-reload.
//
// state | meaning
// IDLE  | counter parked; count holds, waits for load
// RUN   | counting down on en strobes; count is always >= 1 here
module countdown16
  import countdown16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;
  logic [WIDTH-1:0] w_count_dec;
  logic             w_at_one;

  Dec16 #(.WIDTH(WIDTH)) u_dec (
    .in  (r_count),
    .out (w_count_dec)
  );

  assign w_at_one = (r_count == WIDTH'(1));

  // Single FSM/counter register block; priority load > stop > en, done defaults low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        if (in != '0) begin
          r_count  <= in;
          r_reload <= in;
          r_state  <= ST_RUN;
        end else begin
          // A zero-length period completes at once.
          r_count <= '0;
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end
      end else if (r_state == ST_RUN) begin
        if (stop) begin
          r_state <= ST_IDLE;
        end else if (en) begin
          if (!w_at_one) begin
            r_count <= w_count_dec;
          end else if (auto_reload) begin
            // Skip the zero value so the period is exactly r_reload ticks.
            r_count <= r_reload;
            r_done  <= 1'b1;
          end else begin
            r_count <= '0;
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  assign count = r_count;
  assign busy  = (r_state == ST_RUN);
  assign done  = r_done;

endmodule

// File: tb/tb_countdown16.sv
module tb_countdown16;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] in;
  logic        en;
  logic        stop;
  logic        auto_reload;
  logic [15:0] count;
  logic        busy;
  logic        done;

  typedef struct {
    string       name;
    logic [15:0] c;
    logic        b;
    logic        d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stim_done = 0;

  countdown16 #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .in          (in),
    .en          (en),
    .stop        (stop),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] ec, input logic eb, input logic ed);
    n_checks++;
    if (count === ec && busy === eb && done === ed) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got count=%h busy=%b done=%b, expected count=%h busy=%b done=%b",
               name, count, busy, done, ec, eb, ed);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected post-edge outputs.
  task automatic step(input string name, input logic ld, input logic [15:0] din, input logic e,
                      input logic s, input logic ar, input logic [15:0] ec, input logic eb,
                      input logic ed);
    exp_t x;
    @(negedge clk);
    load = ld; in = din; en = e; stop = s; auto_reload = ar;
    x.name = name; x.c = ec; x.b = eb; x.d = ed;
    exp_q.push_back(x);
  endtask

  // Drive without expectation (long runs).
  task automatic drive(input logic ld, input logic [15:0] din, input logic e, input logic s,
                       input logic ar);
    @(negedge clk);
    load = ld; in = din; en = e; stop = s; auto_reload = ar;
  endtask

  // Monitor: outputs are registered, so compare just after each rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check(x.name, x.c, x.b, x.d);
      end
    end
  end

  initial begin
    reset = 1'b1; load = 0; in = 0; en = 0; stop = 0; auto_reload = 0;
    #1;
    check("reset_state", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step("idle_after_reset", 0, 16'd0, 1, 0, 0, 16'd0, 0, 0);

    // load 3, run to terminal count
    step("l3_load", 1, 16'd3, 1, 0, 0, 16'd3, 1, 0);
    step("l3_c2",   0, 16'd0, 1, 0, 0, 16'd2, 1, 0);
    step("l3_c1",   0, 16'd0, 1, 0, 0, 16'd1, 1, 0);
    step("l3_c0",   0, 16'd0, 1, 0, 0, 16'd0, 0, 1);
    step("l3_idle", 0, 16'd0, 1, 0, 0, 16'd0, 0, 0);

    // load 2 with auto-reload
    step("ar2_load", 1, 16'd2, 1, 0, 1, 16'd2, 1, 0);
    step("ar2_c1a",  0, 16'd0, 1, 0, 1, 16'd1, 1, 0);
    step("ar2_c2a",  0, 16'd0, 1, 0, 1, 16'd2, 1, 1);
    step("ar2_c1b",  0, 16'd0, 1, 0, 1, 16'd1, 1, 0);
    step("ar2_c2b",  0, 16'd0, 1, 0, 1, 16'd2, 1, 1);
    step("ar2_c1c",  0, 16'd0, 1, 0, 1, 16'd1, 1, 0);
    step("ar2_stop", 0, 16'd0, 0, 1, 1, 16'd1, 0, 0);

    // load 5, en toggling
    step("en_load", 1, 16'd5, 0, 0, 0, 16'd5, 1, 0);
    step("en_1a",   0, 16'd0, 1, 0, 0, 16'd4, 1, 0);
    step("en_0a",   0, 16'd0, 0, 0, 0, 16'd4, 1, 0);
    step("en_1b",   0, 16'd0, 1, 0, 0, 16'd3, 1, 0);
    step("en_0b",   0, 16'd0, 0, 0, 0, 16'd3, 1, 0);
    step("en_stop", 0, 16'd0, 0, 1, 0, 16'd3, 0, 0);

    // zero-length period
    step("z_load", 1, 16'd0, 0, 0, 0, 16'd0, 0, 1);
    step("z_after", 0, 16'd0, 0, 0, 0, 16'd0, 0, 0);

    // stop beats en; load beats stop
    step("st_load",   1, 16'd4, 0, 0, 0, 16'd4, 1, 0);
    step("st_stopen", 0, 16'd0, 1, 1, 0, 16'd4, 0, 0);
    step("st_idle_en",0, 16'd0, 1, 0, 0, 16'd4, 0, 0);
    step("st_ldstop", 1, 16'd7, 0, 1, 0, 16'd7, 1, 0);
    step("st_dec",    0, 16'd0, 1, 0, 0, 16'd6, 1, 0);

    // restart mid-run, then load 0 mid-run
    step("rs_load2", 1, 16'd2, 1, 0, 0, 16'd2, 1, 0);
    step("rs_c1",    0, 16'd0, 1, 0, 0, 16'd1, 1, 0);
    step("rs_c0",    0, 16'd0, 1, 0, 0, 16'd0, 0, 1);
    step("rz_load9", 1, 16'd9, 1, 0, 0, 16'd9, 1, 0);
    step("rz_load0", 1, 16'd0, 1, 0, 0, 16'd0, 0, 1);

    // period of 1 with auto-reload: done every tick, count stays 1
    step("p1_load", 1, 16'd1, 0, 0, 1, 16'd1, 1, 0);
    step("p1_t1",   0, 16'd0, 1, 0, 1, 16'd1, 1, 1);
    step("p1_t2",   0, 16'd0, 1, 0, 1, 16'd1, 1, 1);
    step("p1_hold", 0, 16'd0, 0, 0, 1, 16'd1, 1, 0);
    step("p1_stop", 0, 16'd0, 0, 1, 1, 16'd1, 0, 0);

    // full-range period
    step("max_load", 1, 16'hFFFF, 0, 0, 0, 16'hFFFF, 1, 0);
    step("max_dec",  0, 16'd0,    1, 0, 0, 16'hFFFE, 1, 0);
    for (int i = 0; i < 65532; i++) drive(0, 16'd0, 1, 0, 0);
    step("max_c1",   0, 16'd0, 1, 0, 0, 16'd1, 1, 0);
    step("max_c0",   0, 16'd0, 1, 0, 0, 16'd0, 0, 1);

    // asynchronous reset mid-count
    step("ar_load", 1, 16'h8000, 0, 0, 0, 16'h8000, 1, 0);
    step("ar_dec",  0, 16'd0,    1, 0, 0, 16'h7FFF, 1, 0);
    @(negedge clk);
    en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step("post_rst_a", 0, 16'd0, 1, 0, 0, 16'd0, 0, 0);
    step("post_rst_b", 0, 16'd0, 1, 0, 1, 16'd0, 0, 0);

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
